// File: rtl/noc_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// noc_port_arbiter_pkg
// Shared definitions for the mesh injection-port arbiter:
//   TDATAW      - default payload width per beat
//   TDESTW      - default destination router ID width
//   arb_state_t - arbiter FSM states (IDLE: arbitrating, BURST: packet open)
// ---------------------------------------------------------------------------
package noc_port_arbiter_pkg;

    localparam int TDATAW = 32;
    localparam int TDESTW = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/noc_port_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. Scans the request vector starting at
// index ptr and wrapping at N-1; the first requester found wins.
// Ports:
//   req     [N-1:0]    request per source
//   ptr     [PTRW-1:0] index that has highest priority this round
//   gnt_idx [PTRW-1:0] winning index (0 when nobody requests)
//   gnt_any            at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N    = 4,
    parameter int PTRW = 2
) (
    input  logic [N-1:0]    req,
    input  logic [PTRW-1:0] ptr,
    output logic [PTRW-1:0] gnt_idx,
    output logic            gnt_any
);

    // Candidate index in priority order: w_cand[0] = ptr, w_cand[k] = ptr+k mod N.
    logic [PTRW-1:0] w_cand [N];

    always_comb begin
        for (int k = 0; k < N; k++) begin
            w_cand[k] = PTRW'((int'(ptr) + k) % N);
        end
    end

    // Scanning from lowest priority to highest lets the highest-priority
    // requester overwrite any earlier match.
    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves
        // it unassigned and no latch is inferred.
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[w_cand[k]]) begin
                gnt_idx = w_cand[k];
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_port_arbiter.sv
// ---------------------------------------------------------------------------
// noc_port_arbiter
// Shares one mesh injection port between NUM_SRC AXI-Stream sources. A packet
// is granted round-robin in IDLE (one bubble cycle per packet), then streamed
// beat by beat through a single output register until its TLAST beat.
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   ARB_EN              permits new grants (never truncates an open packet)
//   S_TVALID/TREADY     per-source handshake
//   S_TDATA/TLAST/TDEST per-source beat, source i at slice i
//   M_TVALID/TDATA/TLAST/TDEST, M_TREADY  registered beat to the mesh
//   GRANT_O             current or most recent granted source
//   BUSY_O              high while a packet is open (BURST)
//   PKT_CNT_O           packets fully forwarded, wraps at 2^CNTW
// ---------------------------------------------------------------------------
module noc_port_arbiter #(
    parameter int  NUM_SRC = 4,
    parameter int  TDATAW  = noc_port_arbiter_pkg::TDATAW,
    parameter int  TDESTW  = noc_port_arbiter_pkg::TDESTW,
    parameter int  CNTW    = 16,
    localparam int PTRW    = $clog2(NUM_SRC)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      ARB_EN,
    input  logic [NUM_SRC-1:0]        S_TVALID,
    output logic [NUM_SRC-1:0]        S_TREADY,
    input  logic [NUM_SRC*TDATAW-1:0] S_TDATA,
    input  logic [NUM_SRC-1:0]        S_TLAST,
    input  logic [NUM_SRC*TDESTW-1:0] S_TDEST,
    output logic                      M_TVALID,
    output logic [TDATAW-1:0]         M_TDATA,
    output logic                      M_TLAST,
    output logic [TDESTW-1:0]         M_TDEST,
    input  logic                      M_TREADY,
    output logic [PTRW-1:0]           GRANT_O,
    output logic                      BUSY_O,
    output logic [CNTW-1:0]           PKT_CNT_O
);

    import noc_port_arbiter_pkg::*;

    arb_state_t        r_state;
    logic [PTRW-1:0]   r_ptr;
    logic [PTRW-1:0]   r_grant;
    logic              r_m_valid;
    logic [TDATAW-1:0] r_m_data;
    logic              r_m_last;
    logic [TDESTW-1:0] r_m_dest;
    logic [CNTW-1:0]   r_pkt_cnt;

    logic [PTRW-1:0]   w_gnt_idx;
    logic              w_gnt_any;
    logic              w_out_free;
    logic              w_sel_valid;
    logic              w_sel_last;
    logic [TDATAW-1:0] w_sel_data;
    logic [TDESTW-1:0] w_sel_dest;
    logic              w_accept;
    logic              w_m_hs;

    rr_arbiter #(
        .N    (NUM_SRC),
        .PTRW (PTRW)
    ) u_rr (
        .req     (S_TVALID),
        .ptr     (r_ptr),
        .gnt_idx (w_gnt_idx),
        .gnt_any (w_gnt_any)
    );

    // Beat of the granted source.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        w_sel_dest  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_grant == PTRW'(i)) begin
                w_sel_valid = S_TVALID[i];
                w_sel_last  = S_TLAST[i];
                w_sel_data  = S_TDATA[i*TDATAW +: TDATAW];
                w_sel_dest  = S_TDEST[i*TDESTW +: TDESTW];
            end
        end
    end

    // The output register can take a beat when empty or draining this cycle,
    // which keeps a packet at one beat per cycle under full M_TREADY.
    assign w_out_free = !r_m_valid || M_TREADY;
    assign w_accept   = (r_state == BURST) && w_sel_valid && w_out_free;
    assign w_m_hs     = r_m_valid && M_TREADY;

    // Only the granted source sees ready, and only in BURST; IDLE is the
    // arbitration bubble.
    always_comb begin
        S_TREADY = '0;
        if (r_state == BURST) begin
            S_TREADY[r_grant] = w_out_free;
        end
    end

    // Grant FSM. ARB_EN gates only the IDLE->BURST decision, so an open packet
    // always runs to its TLAST; a stalled source just holds the port.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            // NOTE: state uses non-blocking assignments so every register
            // samples pre-edge values, independent of block ordering.
            r_state <= IDLE;
            r_ptr   <= '0;
            r_grant <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (ARB_EN && w_gnt_any) begin
                        r_grant <= w_gnt_idx;
                        r_state <= BURST;
                    end
                end
                BURST: begin
                    if (w_accept && w_sel_last) begin
                        r_state <= IDLE;
                        r_ptr   <= (r_grant == PTRW'(NUM_SRC - 1)) ? '0 : r_grant + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Output register: load on accept, otherwise drop valid after a handshake.
    // Holding data untouched while stalled keeps M_* stable.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_last  <= 1'b0;
            r_m_dest  <= '0;
        end else if (w_accept) begin
            r_m_valid <= 1'b1;
            r_m_data  <= w_sel_data;
            r_m_last  <= w_sel_last;
            r_m_dest  <= w_sel_dest;
        end else if (w_m_hs) begin
            r_m_valid <= 1'b0;
        end
    end

    // Packet counter counts TLAST handshakes on the mesh side, wrapping freely.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pkt_cnt <= '0;
        end else if (w_m_hs && r_m_last) begin
            r_pkt_cnt <= r_pkt_cnt + 1'b1;
        end
    end

    assign M_TVALID  = r_m_valid;
    assign M_TDATA   = r_m_data;
    assign M_TLAST   = r_m_last;
    assign M_TDEST   = r_m_dest;
    assign GRANT_O   = r_grant;
    assign BUSY_O    = (r_state == BURST);
    assign PKT_CNT_O = r_pkt_cnt;

endmodule
